// File: rtl/bp_be_commit_trace_buffer.sv
// bp_be_commit_trace_buffer
// Commit-trace capture for the backend. Dispatched instructions are followed
// through a shadow pipeline that mirrors the dispatch-to-commit depth. Stage
// poison and core freeze are applied along the way. Each surviving commit is
// combined with its writeback result and trap/ret flags into a record. Records
// go into a ring FIFO that is drained over a valid/yumi handshake.
// Commit and drop counters run alongside the FIFO. An optional trigger mode
// freezes capture a fixed number of commits after the first trap.

module bp_be_commit_trace_buffer #(
    parameter int vaddr_width_p  = 39,
    parameter int instr_width_p  = 32,
    parameter int data_width_p   = 64,
    parameter int stages_p       = 3,
    parameter int els_p          = 16,
    parameter int stop_on_trap_p = 0,
    parameter int post_trig_p    = 4,
    localparam int rec_width_lp  = vaddr_width_p + instr_width_p + data_width_p + 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     freeze_i,

    input  logic                     dispatch_v_i,
    input  logic [vaddr_width_p-1:0] dispatch_pc_i,
    input  logic [instr_width_p-1:0] dispatch_instr_i,
    input  logic [stages_p-1:0]      poison_i,

    input  logic [data_width_p-1:0]  result_i,
    input  logic                     trap_v_i,
    input  logic                     ret_v_i,

    output logic                     rd_v_o,
    output logic [rec_width_lp-1:0]  rd_data_o,
    input  logic                     rd_yumi_i,

    output logic [63:0]              commit_cnt_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     stopped_o
);

    localparam int       ptr_width_lp = $clog2(els_p);
    localparam bit       trig_en_lp   = (stop_on_trap_p != 0);
    localparam bit [7:0] post_trig_lp = 8'(post_trig_p);

    typedef enum logic [1:0] {
        e_run,
        e_armed,
        e_stopped
    } state_e;

    // Shadow pipeline state.
    logic [stages_p-1:0]      stage_v_q, stage_v_d;
    logic [vaddr_width_p-1:0] stage_pc_q    [stages_p];
    logic [vaddr_width_p-1:0] stage_pc_d    [stages_p];
    logic [instr_width_p-1:0] stage_instr_q [stages_p];
    logic [instr_width_p-1:0] stage_instr_d [stages_p];

    // Commit and capture signals.
    logic                    commit_v;
    logic [rec_width_lp-1:0] commit_rec;
    logic                    wr_req;
    logic                    wr_en;
    logic                    drop_v;
    logic                    rd_en;

    // FIFO storage and pointers. Each pointer carries one extra wrap bit.
    logic [rec_width_lp-1:0] mem_q [els_p];
    logic [ptr_width_lp:0]   wptr_q, wptr_d;
    logic [ptr_width_lp:0]   rptr_q, rptr_d;
    logic                    fifo_empty;
    logic                    fifo_full;

    // Counters.
    logic [63:0] commit_cnt_q, commit_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Trigger FSM.
    state_e      state_q, state_d;
    logic [7:0]  trig_cnt_q, trig_cnt_d;
    logic        stopped;

    // Next state of the shadow pipe. Stage 0 takes the new dispatch. Each later
    // stage takes its predecessor. An entry dies if its current stage is
    // poisoned. Freeze empties every stage. The pipe never stalls, so the
    // data fields simply shift every cycle.
    always_comb begin
        stage_v_d        = '0;
        stage_pc_d       = stage_pc_q;
        stage_instr_d    = stage_instr_q;
        stage_v_d[0]     = dispatch_v_i & ~freeze_i;
        stage_pc_d[0]    = dispatch_pc_i;
        stage_instr_d[0] = dispatch_instr_i;
        for (int k = 1; k < stages_p; k++) begin
            stage_v_d[k]     = stage_v_q[k-1] & ~poison_i[k-1] & ~freeze_i;
            stage_pc_d[k]    = stage_pc_q[k-1];
            stage_instr_d[k] = stage_instr_q[k-1];
        end
    end

    // Stage valid bits need reset so the pipe comes up empty. The pc/instr
    // payload is only meaningful when its valid bit is set, so it is left
    // unreset in the separate block below.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_v_q <= '0;
        end else begin
            stage_v_q <= stage_v_d;
        end
    end

    // Payload shift register for the shadow pipe.
    always_ff @(posedge clk_i) begin
        stage_pc_q    <= stage_pc_d;
        stage_instr_q <= stage_instr_d;
    end

    // An instruction commits from the last stage unless that stage is poisoned
    // or the core is frozen. The record joins the tracked pc/instr with
    // result and flags sampled in the commit cycle, with pc in the MSBs.
    always_comb begin
        commit_v   = stage_v_q[stages_p-1] & ~poison_i[stages_p-1] & ~freeze_i;
        commit_rec = {stage_pc_q[stages_p-1], stage_instr_q[stages_p-1],
                      result_i, trap_v_i, ret_v_i};
    end

    // FIFO control. The FIFO is full when the indices match and the wrap bits
    // differ. A write into a full FIFO still goes in when the head is consumed
    // in the same cycle, because the slot being freed is the one being written.
    // Otherwise the write is dropped and counted. A yumi on an empty FIFO is
    // ignored rather than corrupting the pointers.
    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
                   & (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]);
        wr_req     = commit_v & ~stopped;
        rd_en      = rd_yumi_i & ~fifo_empty;
        wr_en      = wr_req & (~fifo_full | rd_yumi_i);
        drop_v     = wr_req & fifo_full & ~rd_yumi_i;
        wptr_d     = wr_en ? (wptr_q + {{ptr_width_lp{1'b0}}, 1'b1}) : wptr_q;
        rptr_d     = rd_en ? (rptr_q + {{ptr_width_lp{1'b0}}, 1'b1}) : rptr_q;
    end

    // The pointers carry all FIFO occupancy information. Resetting them
    // discards the contents immediately, so the storage itself needs no reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Record storage. It is written at the tail when a write is accepted.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q[ptr_width_lp-1:0]] <= commit_rec;
        end
    end

    // Commit counting ignores capture and stop state and wraps naturally. The
    // drop counter saturates so that a long overflow stays visible.
    always_comb begin
        commit_cnt_d = commit_cnt_q + 64'(commit_v);
        drop_cnt_d   = drop_cnt_q;
        if (drop_v && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter registers. Reset clears them asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Trigger FSM next state. The first trap commit arms the trigger. That
    // trap record is captured because stopped is still low. Each later commit
    // counts down. The commit that reaches zero is still captured, and
    // capture freezes from the next cycle. A trap seen while armed does not
    // restart the countdown. With trigger mode disabled the FSM stays in
    // e_run.
    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        unique case (state_q)
            e_run: begin
                if (trig_en_lp && commit_v && trap_v_i) begin
                    if (post_trig_lp == 8'd0) begin
                        state_d = e_stopped;
                    end else begin
                        state_d    = e_armed;
                        trig_cnt_d = post_trig_lp;
                    end
                end
            end
            e_armed: begin
                if (commit_v) begin
                    trig_cnt_d = trig_cnt_q - 8'd1;
                    if (trig_cnt_q == 8'd1) begin
                        state_d = e_stopped;
                    end
                end
            end
            e_stopped: begin
                state_d = e_stopped;
            end
            default: begin
                state_d = e_run;
            end
        endcase
    end

    // Trigger state register. Only reset leaves e_stopped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_run;
            trig_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
        end
    end

    // Output drive. rd_data_o is forced to zero while the FIFO is empty, so
    // that stale storage is never presented. This includes the reset state.
    always_comb begin
        stopped      = (state_q == e_stopped);
        stopped_o    = stopped;
        rd_v_o       = ~fifo_empty;
        rd_data_o    = fifo_empty ? '0 : mem_q[rptr_q[ptr_width_lp-1:0]];
        commit_cnt_o = commit_cnt_q;
        drop_cnt_o   = drop_cnt_q;
    end

endmodule

// File: tb/tb_bp_be_commit_trace_buffer.sv
// Testbench for bp_be_commit_trace_buffer.
// Instance dut runs with trigger mode off. Instance dutTrig runs with
// stop-on-trap and post_trig_p = 2. Both instances share every stimulus input
// except the read handshake.

module tb_bp_be_commit_trace_buffer;

    localparam int REC = 39 + 32 + 64 + 2;

    typedef struct {
        logic            dispV;
        logic [38:0]     pc;
        logic [31:0]     instr;
        logic [63:0]     result;
        logic            ret;
        logic            yumi;
        logic            expV;
        logic [REC-1:0]  expRec;
        logic [63:0]     expCnt;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            freeze;
    logic            dispV;
    logic [38:0]     dispPc;
    logic [31:0]     dispInstr;
    logic [2:0]      poison;
    logic [63:0]     result;
    logic            trap;
    logic            ret;
    logic            yumi;
    logic            yumiT;

    logic            rv, rvT;
    logic [REC-1:0]  rdata, rdataT;
    logic [63:0]     ccnt, ccntT;
    logic [15:0]     dcnt, dcntT;
    logic            stopped, stoppedT;

    int              nChecks = 0;
    int              nFails  = 0;
    vec_t            vecs[13];
    logic            headV;
    logic [REC-1:0]  headD;

    bp_be_commit_trace_buffer #(
        .vaddr_width_p(39), .instr_width_p(32), .data_width_p(64),
        .stages_p(3), .els_p(16), .stop_on_trap_p(0), .post_trig_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze),
        .dispatch_v_i(dispV), .dispatch_pc_i(dispPc), .dispatch_instr_i(dispInstr),
        .poison_i(poison), .result_i(result), .trap_v_i(trap), .ret_v_i(ret),
        .rd_v_o(rv), .rd_data_o(rdata), .rd_yumi_i(yumi),
        .commit_cnt_o(ccnt), .drop_cnt_o(dcnt), .stopped_o(stopped)
    );

    bp_be_commit_trace_buffer #(
        .vaddr_width_p(39), .instr_width_p(32), .data_width_p(64),
        .stages_p(3), .els_p(16), .stop_on_trap_p(1), .post_trig_p(2)
    ) dutTrig (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze),
        .dispatch_v_i(dispV), .dispatch_pc_i(dispPc), .dispatch_instr_i(dispInstr),
        .poison_i(poison), .result_i(result), .trap_v_i(trap), .ret_v_i(ret),
        .rd_v_o(rvT), .rd_data_o(rdataT), .rd_yumi_i(yumiT),
        .commit_cnt_o(ccntT), .drop_cnt_o(dcntT), .stopped_o(stoppedT)
    );

    // Free-running clock: posedges at 5, 15, 25 ...; negedges at 10, 20 ...
    always #5 clk = ~clk;

    // Safety net so that a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [REC-1:0] mkRec(input logic [38:0] pc, input logic [31:0] ins,
                                             input logic [63:0] res, input logic tr, input logic rt);
        return {pc, ins, res, tr, rt};
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        freeze    = 1'b0;
        dispV     = 1'b0;
        dispPc    = '0;
        dispInstr = '0;
        poison    = '0;
        result    = '0;
        trap      = 1'b0;
        ret       = 1'b0;
        yumi      = 1'b0;
        yumiT     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearInputs();
        dispV     = v.dispV;
        dispPc    = v.pc;
        dispInstr = v.instr;
        result    = v.result;
        ret       = v.ret;
        yumi      = v.yumi;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dispatch(input logic [38:0] pc, input logic [31:0] ins);
        dispV     = 1'b1;
        dispPc    = pc;
        dispInstr = ins;
    endtask

    // Reset is raised mid-cycle, and the outputs are checked before any clock
    // edge arrives. The task returns at a negedge with reset released.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        clearInputs();
        #1;
        checkOutput("rst rd_v", rv, 1'b0);
        checkOutput("rst rd_data", rdata, '0);
        checkOutput("rst commit_cnt", ccnt, '0);
        checkOutput("rst drop_cnt", dcnt, '0);
        checkOutput("rst stopped", stopped, 1'b0);
        checkOutput("rst trig rd_v", rvT, 1'b0);
        checkOutput("rst trig commit_cnt", ccntT, '0);
        checkOutput("rst trig stopped", stoppedT, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pops the head of the selected instance if it is valid. The clock only
    // advances when something was consumed.
    task automatic readHead(input bit trigSel, output logic v, output logic [REC-1:0] d);
        v = trigSel ? rvT : rv;
        d = trigSel ? rdataT : rdata;
        if (v) begin
            if (trigSel) yumiT = 1'b1;
            else         yumi  = 1'b1;
            tick();
            yumi  = 1'b0;
            yumiT = 1'b0;
        end
    endtask

    task automatic setRow(input int i, input logic dv, input logic [38:0] pc, input logic [31:0] ins,
                          input logic [63:0] res, input logic rt, input logic y,
                          input logic ev, input logic [REC-1:0] er, input logic [63:0] ec);
        vecs[i].dispV  = dv;
        vecs[i].pc     = pc;
        vecs[i].instr  = ins;
        vecs[i].result = res;
        vecs[i].ret    = rt;
        vecs[i].yumi   = y;
        vecs[i].expV   = ev;
        vecs[i].expRec = er;
        vecs[i].expCnt = ec;
    endtask

    initial begin
        logic [38:0]    p   [4];
        logic [31:0]    ins [4];
        logic [63:0]    res [4];
        logic [REC-1:0] rec [4];
        logic [REC-1:0] firstRec, lastRec;
        logic [REC-1:0] expTrig [4];
        int             n;

        clearInputs();

        // Table for the basic in-order scenario. Four dispatches from cycle 0
        // commit in cycles 3..6, and the first valid head appears in cycle 4.
        // The third record carries ret. Rows 8..11 drain the FIFO.
        for (int i = 0; i < 4; i++) begin
            p[i]   = 39'h80000000 + 39'(4 * i);
            ins[i] = 32'h00100093 + 32'(i);
            res[i] = 64'hCAFE000000000000 + 64'(i);
            rec[i] = mkRec(p[i], ins[i], res[i], 1'b0, (i == 2));
        end
        setRow(0,  1, p[0], ins[0], '0,     0, 0, 0, '0,     64'd0);
        setRow(1,  1, p[1], ins[1], '0,     0, 0, 0, '0,     64'd0);
        setRow(2,  1, p[2], ins[2], '0,     0, 0, 0, '0,     64'd0);
        setRow(3,  1, p[3], ins[3], res[0], 0, 0, 0, '0,     64'd0);
        setRow(4,  0, '0,   '0,     res[1], 0, 0, 1, rec[0], 64'd1);
        setRow(5,  0, '0,   '0,     res[2], 1, 0, 1, rec[0], 64'd2);
        setRow(6,  0, '0,   '0,     res[3], 0, 0, 1, rec[0], 64'd3);
        setRow(7,  0, '0,   '0,     '0,     0, 0, 1, rec[0], 64'd4);
        setRow(8,  0, '0,   '0,     '0,     0, 1, 1, rec[0], 64'd4);
        setRow(9,  0, '0,   '0,     '0,     0, 1, 1, rec[1], 64'd4);
        setRow(10, 0, '0,   '0,     '0,     0, 1, 1, rec[2], 64'd4);
        setRow(11, 0, '0,   '0,     '0,     0, 1, 1, rec[3], 64'd4);
        setRow(12, 0, '0,   '0,     '0,     0, 0, 0, '0,     64'd4);

        $display("[TB] in-order capture vectors");
        doReset();
        for (int i = 0; i < 13; i++) begin
            checkOutput($sformatf("vec%0d rd_v", i), rv, vecs[i].expV);
            if (vecs[i].expV) checkOutput($sformatf("vec%0d rd_data", i), rdata, vecs[i].expRec);
            checkOutput($sformatf("vec%0d commit_cnt", i), ccnt, vecs[i].expCnt);
            applyStimulus(vecs[i]);
            tick();
        end
        clearInputs();

        // Poison: the second instruction sits in stage 1 during cycle 3, and
        // poison bit 1 kills it there.
        $display("[TB] poison sequence");
        doReset();
        for (int c = 0; c < 8; c++) begin
            clearInputs();
            if (c < 3) dispatch(39'h80001000 + 39'(4 * c), 32'h00200013 + 32'(c));
            if (c == 3) poison = 3'b010;
            result = 64'h5000 + 64'(c);
            tick();
        end
        clearInputs();
        checkOutput("poison commit_cnt", ccnt, 64'd2);
        readHead(0, headV, headD);
        checkOutput("poison head0 v", headV, 1'b1);
        checkOutput("poison head0", headD, mkRec(39'h80001000, 32'h00200013, 64'h5003, 0, 0));
        readHead(0, headV, headD);
        checkOutput("poison head1 v", headV, 1'b1);
        checkOutput("poison head1", headD, mkRec(39'h80001008, 32'h00200015, 64'h5005, 0, 0));
        readHead(0, headV, headD);
        checkOutput("poison empty", headV, 1'b0);

        // Overflow: 20 commits into 16 slots leave 4 drops. Then one commit
        // arrives while full, together with a yumi, and must be accepted.
        $display("[TB] overflow sequence");
        doReset();
        for (int c = 0; c < 24; c++) begin
            clearInputs();
            if (c < 20) dispatch(39'h80002000 + 39'(4 * c), 32'h00300013 + 32'(c));
            result = 64'h7000 + 64'(c);
            tick();
        end
        clearInputs();
        checkOutput("ovf drop_cnt", dcnt, 16'd4);
        checkOutput("ovf commit_cnt", ccnt, 64'd20);
        checkOutput("ovf rd_v", rv, 1'b1);
        dispatch(39'h80003000, 32'h00400013);
        tick();
        clearInputs();
        tick();
        tick();
        result = 64'hABCD;
        yumi   = 1'b1;
        tick();
        clearInputs();
        checkOutput("full+yumi drop_cnt", dcnt, 16'd4);
        checkOutput("full+yumi commit_cnt", ccnt, 64'd21);
        n = 0;
        firstRec = '0;
        lastRec  = '0;
        for (int k = 0; k < 20; k++) begin
            readHead(0, headV, headD);
            if (headV) begin
                if (n == 0) firstRec = headD;
                lastRec = headD;
                n++;
            end
        end
        checkOutput("full+yumi occupancy", 32'(n), 32'd16);
        checkOutput("full+yumi first", firstRec, mkRec(39'h80002004, 32'h00300014, 64'h7004, 0, 0));
        checkOutput("full+yumi last", lastRec, mkRec(39'h80003000, 32'h00400013, 64'hABCD, 0, 0));

        // Trigger: commits A, B(trap), C, D, E in cycles 3..7. With two
        // post-trigger commits, D is the last record captured, and stopped
        // rises in cycle 7.
        $display("[TB] stop-on-trap sequence");
        doReset();
        for (int c = 0; c < 10; c++) begin
            if (c == 6) checkOutput("trig stopped before D", stoppedT, 1'b0);
            if (c == 7) checkOutput("trig stopped after D", stoppedT, 1'b1);
            clearInputs();
            if (c < 5) dispatch(39'h80004000 + 39'(4 * c), 32'h00500013 + 32'(c));
            result = 64'h9000 + 64'(c);
            trap   = (c == 4);
            tick();
        end
        clearInputs();
        checkOutput("trig commit_cnt", ccntT, 64'd5);
        checkOutput("trig drop_cnt", dcntT, 16'd0);
        checkOutput("trig stopped held", stoppedT, 1'b1);
        checkOutput("notrig stopped", stopped, 1'b0);
        for (int k = 0; k < 4; k++) begin
            expTrig[k] = mkRec(39'h80004000 + 39'(4 * k), 32'h00500013 + 32'(k),
                               64'h9003 + 64'(k), (k == 1), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            readHead(1, headV, headD);
            checkOutput($sformatf("trig rec%0d v", k), headV, 1'b1);
            checkOutput($sformatf("trig rec%0d", k), headD, expTrig[k]);
        end
        readHead(1, headV, headD);
        checkOutput("trig empty after D", headV, 1'b0);

        // Freeze: all three instructions are in flight in cycle 3, when freeze
        // is pulsed for one cycle.
        $display("[TB] freeze sequence");
        doReset();
        for (int c = 0; c < 10; c++) begin
            clearInputs();
            if (c < 3) dispatch(39'h80005000 + 39'(4 * c), 32'h00600013 + 32'(c));
            if (c == 3) freeze = 1'b1;
            tick();
        end
        clearInputs();
        checkOutput("freeze commit_cnt", ccnt, 64'd0);
        checkOutput("freeze rd_v", rv, 1'b0);
        checkOutput("freeze trig commit_cnt", ccntT, 64'd0);

        // Five entries queued, then an asynchronous reset. The checks inside
        // doReset happen before the next clock edge.
        $display("[TB] async reset sequence");
        doReset();
        for (int c = 0; c < 9; c++) begin
            clearInputs();
            if (c < 5) dispatch(39'h80006000 + 39'(4 * c), 32'h00700013 + 32'(c));
            tick();
        end
        clearInputs();
        checkOutput("queued rd_v", rv, 1'b1);
        checkOutput("queued commit_cnt", ccnt, 64'd5);
        doReset();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bp_be_commit_trace_buffer.md
Name: bp_be_commit_trace_buffer

Overview:
- Parametrised commit-trace capture block for the BE; successor to the per-core calc tracer.
- Tracks dispatched instructions through a configurable-depth shadow pipeline and applies per-stage poison.
- Captures committed records (pc, instr, result, trap/ret flags) into a ring FIFO that is drained over a valid/yumi interface.
- Adds commit/drop counters and an optional stop-on-trap trigger mode, so the block is usable from both a nonsynth testbench and an on-chip debug path.

Parameters:
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- data_width_p, 64, writeback result width
- stages_p, 3, dispatch-to-commit depth (>=1)
- els_p, 16, FIFO entries (power of 2, >=2)
- stop_on_trap_p, 0, 1 = freeze capture after a trap plus post_trig_p commits
- post_trig_p, 4, commits captured after the trigger commit (0..255)
- rec_width_lp, vaddr_width_p+instr_width_p+data_width_p+2, record width (localparam)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- freeze_i  in  1  core frozen; flushes the shadow pipe
- dispatch_v_i  in  1  instruction dispatched this cycle
- dispatch_pc_i  in  vaddr_width_p  dispatched PC
- dispatch_instr_i  in  instr_width_p  dispatched instruction
- poison_i  in  stages_p  poison for stage k entry
- result_i  in  data_width_p  writeback result at commit
- trap_v_i  in  1  commit-stage instruction traps
- ret_v_i  in  1  commit-stage instruction is xRET
- rd_v_o  out  1  FIFO head valid
- rd_data_o  out  rec_width_lp  {pc, instr, result, trap, ret}, pc in MSBs
- rd_yumi_i  in  1  consume head (legal only when rd_v_o)
- commit_cnt_o  out  64  total commits, wraps
- drop_cnt_o  out  16  records lost to full FIFO, saturating
- stopped_o  out  1  capture halted by trigger

Behaviour:
- Reset (async assert, sync use after deassert):
  - all stage valids 0; FIFO empty; rd_v_o 0; rd_data_o 0
  - commit_cnt_o 0; drop_cnt_o 0; stopped_o 0; FSM in e_run
- Shadow pipe: stage[0] loads {dispatch_v_i & ~freeze_i, pc, instr} every cycle. Stage[k] loads stage[k-1] with valid cleared when poison_i[k-1] is high. No stall.
- freeze_i=1: every stage valid is cleared at the next edge.
- Commit: commit_v = stage[stages_p-1].valid & ~poison_i[stages_p-1] & ~freeze_i.
  - An instruction dispatched in cycle t commits in cycle t+stages_p.
  - result_i, trap_v_i and ret_v_i are sampled in that commit cycle.
- commit_cnt_o increments on every commit_v, independent of capture or stop state.
- Capture write: wr = commit_v & ~stopped_o.
  - Not full: record written.
  - Full & ~rd_yumi_i: record dropped; drop_cnt_o += 1, saturating at 16'hFFFF.
  - Full & rd_yumi_i in the same cycle: write accepted, no drop.
- Read: rd_v_o = ~empty; rd_data_o = head entry. No write-to-read bypass; a write into an empty FIFO gives rd_v_o=1 the following cycle.
- Pointers: log2(els_p) bits plus a wrap bit; full = indices equal and wrap bits differ.
- Trigger FSM, only when stop_on_trap_p=1 (otherwise fixed in e_run):
  - e_run: commit_v & trap_v_i -> e_armed with cnt=post_trig_p; if post_trig_p==0 -> e_stopped directly. The trap record itself is captured.
  - e_armed: each commit_v (captured or dropped) decrements cnt; the commit taking cnt to 0 is still captured, then -> e_stopped. A trap while armed does not reload cnt.
  - e_stopped: stopped_o=1; no further writes and no drop counting; reads continue. Leaves only by reset.
- ret_v_i is recorded only; it has no effect on the FSM.
- Reset mid-operation discards FIFO contents and counts immediately, without waiting for a clock.

Test Plan:
- Dispatch pc=0x80000000..0x8000000C (4 instrs), stages_p=3, no poison -> 4 records in order, first rd_v_o in cycle t0+4; commit_cnt_o=4.
- Dispatch 3 instrs with poison_i[1] pulsed on the 2nd -> only pc 1st/3rd captured; commit_cnt_o=2.
- 20 back-to-back commits, els_p=16, no reads -> 16 records, drop_cnt_o=4. Then full with commit and yumi in the same cycle -> drop_cnt_o unchanged, occupancy stays 16.
- stop_on_trap_p=1, post_trig_p=2: commits A, B(trap), C, D, E -> FIFO holds A, B, C, D; stopped_o rises after D; commit_cnt_o=5; drop_cnt_o=0.
- freeze_i asserted for 1 cycle with 3 instrs in flight -> none commit; commit_cnt_o unchanged.
- Assert reset_i asynchronously with 5 entries queued -> rd_v_o=0 and counters 0 before the next clock edge.
